// File: rtl/t04_mem_bus_responder.sv
// Memory-side responder: turns one arbitrated request into a Wishbone classic
// single-beat master cycle, with a wait-state timeout that aborts the cycle.
module t04_mem_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        write_to_mem,
    input  logic        read_to_mem,
    input  logic [31:0] adr_to_mem,
    input  logic [31:0] data_to_mem,
    input  logic [3:0]  sel_to_mem,
    output logic [31:0] data_from_mem,
    output logic        mem_busy,
    output logic        bus_error,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q;
    logic [15:0] wait_cnt_q;
    logic        timeout_hit_d;

    // Last permitted wait cycle; an ack in the same cycle still takes priority.
    always_comb begin
        timeout_hit_d = 1'b0;
        if (wait_cnt_q == TIMEOUT_LAST) begin
            timeout_hit_d = 1'b1;
        end else begin
            timeout_hit_d = 1'b0;
        end
    end

    // Request FSM; the wb_* output registers double as the latched request copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 16'd0;
            data_from_mem <= 32'd0;
            mem_busy      <= 1'b0;
            bus_error     <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= 32'd0;
            wb_dat_o      <= 32'd0;
            wb_sel_o      <= 4'd0;
        end else begin
            bus_error <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (write_to_mem || read_to_mem) begin
                        state_q    <= REQ;
                        wait_cnt_q <= 16'd0;
                        mem_busy   <= 1'b1;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= write_to_mem;
                        wb_adr_o   <= adr_to_mem;
                        wb_dat_o   <= data_to_mem;
                        wb_sel_o   <= sel_to_mem;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    wait_cnt_q <= wait_cnt_q + 16'd1;
                    if (wb_ack_i || timeout_hit_d) begin
                        state_q  <= DONE;
                        mem_busy <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= 32'd0;
                        wb_dat_o <= 32'd0;
                        wb_sel_o <= 4'd0;
                        if (wb_ack_i) begin
                            if (!wb_we_o) begin
                                data_from_mem <= wb_dat_i;
                            end else begin
                                data_from_mem <= data_from_mem;
                            end
                        end else begin
                            bus_error <= 1'b1;
                            if (!wb_we_o) begin
                                data_from_mem <= ERR_DATA;
                            end else begin
                                data_from_mem <= data_from_mem;
                            end
                        end
                    end else begin
                        state_q <= REQ;
                    end
                end
                DONE: begin
                    // Strobes are still held by the requester here; ignoring them
                    // guarantees a gap between back-to-back requests.
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_busy <= 1'b0;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    wb_adr_o <= 32'd0;
                    wb_dat_o <= 32'd0;
                    wb_sel_o <= 4'd0;
                end
            endcase
        end
    end

endmodule
